// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder: byte RAM window, programmable wait states, ready handshake
// Optional write protection of the window bottom is enabled by defining MEM_RESP_WP_EN.
module mem_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          RAM_AW      = 10,
  parameter int          WAIT_STATES = 1,
  parameter int          WP_SIZE     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_in,
  input  logic        n_oe_mem,
  input  logic        n_we_mem,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        n_mem_rdy,
  output logic        bus_err,
  output logic        wp_hit
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

`ifdef MEM_RESP_WP_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  localparam logic [31:0] WP_LIM = 32'(WP_SIZE);

  logic [7:0] ram_mem [0:(1<<RAM_AW)-1];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RAM_AW-1:0] off_q, off_d;
  logic              wr_q, wr_d;
  logic [7:0]        d_out_q, d_out_d;
  logic              d_oe_q, d_oe_d;
  logic              n_mem_rdy_q, n_mem_rdy_d;
  logic              bus_err_q, bus_err_d;
  logic              wp_hit_q, wp_hit_d;

  logic              hit, rd_req, wr_req, both_low;
  logic              enter_ready, acc_wr, wp_region, ram_we;
  logic [RAM_AW-1:0] acc_off;

  always_comb begin
    hit      = (addr[15:RAM_AW] == BASE_ADDR[15:RAM_AW]);
    rd_req   = !n_oe_mem && n_we_mem;
    wr_req   = n_oe_mem && !n_we_mem;
    both_low = !n_oe_mem && !n_we_mem;

    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    wr_d        = wr_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    n_mem_rdy_d = n_mem_rdy_q;
    bus_err_d   = bus_err_q;
    wp_hit_d    = 1'b0;
    enter_ready = 1'b0;
    acc_off     = off_q;
    acc_wr      = wr_q;
    ram_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (both_low) begin
          bus_err_d = 1'b1;
        end else if ((rd_req || wr_req) && hit) begin
          off_d   = addr[RAM_AW-1:0];
          wr_d    = wr_req;
          acc_off = addr[RAM_AW-1:0];
          acc_wr  = wr_req;
          if (WAIT_STATES == 0) begin
            enter_ready = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        // Master gave up on the access before we were ready.
        if (wr_q ? n_we_mem : n_oe_mem) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          enter_ready = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        if (n_oe_mem && n_we_mem) begin
          state_d     = S_IDLE;
          n_mem_rdy_d = 1'b1;
          d_oe_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wp_region = (32'(acc_off) < WP_LIM);

    if (enter_ready) begin
      state_d     = S_READY;
      n_mem_rdy_d = 1'b0;
      if (acc_wr) begin
        if (WP_EN && wp_region) begin
          wp_hit_d = 1'b1;
        end else begin
          ram_we = !rst;
        end
      end else begin
        d_out_d = ram_mem[acc_off];
        d_oe_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      off_q       <= '0;
      wr_q        <= 1'b0;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      n_mem_rdy_q <= 1'b1;
      bus_err_q   <= 1'b0;
      wp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      wr_q        <= wr_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      n_mem_rdy_q <= n_mem_rdy_d;
      bus_err_q   <= bus_err_d;
      wp_hit_q    <= wp_hit_d;
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[acc_off] <= d_in;
    end
  end

  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
  assign n_mem_rdy = n_mem_rdy_q;
  assign bus_err   = bus_err_q;
  assign wp_hit    = wp_hit_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - scoreboard bench driving three responders (0, 1, 3 wait states) in parallel
module tb_mem_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] addr;
  logic [7:0]  d_in;
  logic        n_oe_mem, n_we_mem;
  logic [7:0]  d_out [3];
  logic        d_oe [3];
  logic        n_mem_rdy [3];
  logic        bus_err [3];
  logic        wp_hit [3];

  mem_bus_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem),
    .d_out(d_out[0]), .d_oe(d_oe[0]), .n_mem_rdy(n_mem_rdy[0]), .bus_err(bus_err[0]), .wp_hit(wp_hit[0]));
  mem_bus_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem),
    .d_out(d_out[1]), .d_oe(d_oe[1]), .n_mem_rdy(n_mem_rdy[1]), .bus_err(bus_err[1]), .wp_hit(wp_hit[1]));
  mem_bus_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem),
    .d_out(d_out[2]), .d_oe(d_oe[2]), .n_mem_rdy(n_mem_rdy[2]), .bus_err(bus_err[2]), .wp_hit(wp_hit[2]));

`ifdef MEM_RESP_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef struct {
    int         dut;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] mdl [3][1024];
  logic [7:0] last_rd [3];
  int         n_checks = 0;
  int         n_fails  = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  function automatic bit prot(input logic [15:0] a);
    return WP_ON && (a[9:0] < 10'd64);
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s/rdy%0d", tag, i), 16'(n_mem_rdy[i]), 16'd1);
      check_eq($sformatf("%s/doe%0d", tag, i), 16'(d_oe[i]), 16'd0);
    end
  endtask

  // One hit access on all three responders; strobe held until every one has answered.
  task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input bit chk_data, input string tag);
    bit done [3];
    int off;
    bit exp_wp;
    off    = int'(a[9:0]);
    exp_wp = wr && prot(a);
    for (int i = 0; i < 3; i++) done[i] = 1'b0;
    addr = a;
    d_in = d;
    if (wr) n_we_mem = 1'b0;
    else    n_oe_mem = 1'b0;
    if (!wr && chk_data)
      for (int i = 0; i < 3; i++) sb_q.push_back('{dut: i, data: mdl[i][off]});
    for (int n = 0; n <= 20; n++) begin
      idle_cycle();
      for (int i = 0; i < 3; i++) begin
        if (wr)
          check_eq($sformatf("%s/wp%0d_n%0d", tag, i, n), 16'(wp_hit[i]),
                   16'((n == ws_of(i)) && exp_wp));
        if (!done[i] && n_mem_rdy[i] == 1'b0) begin
          done[i] = 1'b1;
          check_eq($sformatf("%s/lat%0d", tag, i), 16'(n), 16'(ws_of(i)));
          if (!wr) begin
            last_rd[i] = d_out[i];
            check_eq($sformatf("%s/doe%0d", tag, i), 16'(d_oe[i]), 16'd1);
            if (chk_data) begin
              for (int j = 0; j < sb_q.size(); j++) begin
                if (sb_q[j].dut == i) begin
                  check_eq($sformatf("%s/data%0d", tag, i), 16'(d_out[i]), 16'(sb_q[j].data));
                  sb_q.delete(j);
                  break;
                end
              end
            end
          end else if (!exp_wp) begin
            mdl[i][off] = d;
          end
        end
      end
      if (done[0] && done[1] && done[2] && (!wr || n >= 4)) break;
    end
    for (int i = 0; i < 3; i++)
      if (!done[i]) check_eq($sformatf("%s/timeout%0d", tag, i), 16'(n_mem_rdy[i]), 16'd0);
    n_oe_mem = 1'b1;
    n_we_mem = 1'b1;
    idle_cycle();
    check_idle_outputs({tag, "/release"});
  endtask

  task automatic miss_read(input logic [15:0] a, input string tag);
    int bad [3];
    for (int i = 0; i < 3; i++) bad[i] = 0;
    addr     = a;
    n_oe_mem = 1'b0;
    for (int n = 0; n < 20; n++) begin
      idle_cycle();
      for (int i = 0; i < 3; i++)
        if (n_mem_rdy[i] !== 1'b1 || d_oe[i] !== 1'b0) bad[i]++;
    end
    n_oe_mem = 1'b1;
    idle_cycle();
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("%s/responded%0d", tag, i), 16'(bad[i]), 16'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    addr     = 16'h0000;
    d_in     = 8'h00;
    n_oe_mem = 1'b1;
    n_we_mem = 1'b1;
    @(negedge clk);
    idle_cycle();
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset/rdy%0d", i), 16'(n_mem_rdy[i]), 16'd1);
      check_eq($sformatf("reset/doe%0d", i), 16'(d_oe[i]), 16'd0);
      check_eq($sformatf("reset/dout%0d", i), 16'(d_out[i]), 16'h00);
      check_eq($sformatf("reset/berr%0d", i), 16'(bus_err[i]), 16'd0);
      check_eq($sformatf("reset/wp%0d", i), 16'(wp_hit[i]), 16'd0);
    end
    rst = 1'b0;
    idle_cycle();

    access(1'b1, 16'h8010, 8'hA5, 1'b1, "wr8010");
    access(1'b0, 16'h8010, 8'h00, 1'b1, "rd8010");
    access(1'b1, 16'h8011, 8'h5A, 1'b1, "wr8011");
    access(1'b1, 16'h83FF, 8'hC3, 1'b1, "wr83ff");
    access(1'b0, 16'h8011, 8'h00, 1'b1, "rd8011");
    access(1'b0, 16'h83FF, 8'h00, 1'b1, "rd83ff");
    access(1'b1, 16'h8040, 8'h96, 1'b1, "wr8040");
    access(1'b0, 16'h8040, 8'h00, 1'b1, "rd8040");

    miss_read(16'h7FFF, "miss7fff");
    miss_read(16'h8400, "miss8400");

    // Protected byte: the pre-read establishes the content a discarded write must preserve.
    access(1'b0, 16'h8005, 8'h00, 1'b0, "pre8005");
    for (int i = 0; i < 3; i++) mdl[i][5] = last_rd[i];
    access(1'b1, 16'h8005, 8'h3C, 1'b1, "wr8005");
    access(1'b0, 16'h8005, 8'h00, 1'b1, "rd8005");

    // Abort: write strobe released during the 3-wait-state unit's second WAIT cycle.
    access(1'b1, 16'h8020, 8'h11, 1'b1, "wr8020");
    addr     = 16'h8020;
    d_in     = 8'h77;
    n_we_mem = 1'b0;
    idle_cycle();
    idle_cycle();
    check_eq("abort/ws3_waiting", 16'(n_mem_rdy[2]), 16'd1);
    n_we_mem = 1'b1;
    idle_cycle();
    check_idle_outputs("abort");
    mdl[0][32] = 8'h77;
    mdl[1][32] = 8'h77;
    access(1'b0, 16'h8020, 8'h00, 1'b1, "rd8020");

    // Reset while the slowest unit sits in READY.
    addr     = 16'h8020;
    n_oe_mem = 1'b0;
    for (int n = 0; n < 4; n++) idle_cycle();
    check_eq("rstready/ws3_rdy", 16'(n_mem_rdy[2]), 16'd0);
    rst = 1'b1;
    idle_cycle();
    check_idle_outputs("rstready");
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("rstready/dout%0d", i), 16'(d_out[i]), 16'h00);
    rst      = 1'b0;
    n_oe_mem = 1'b1;
    idle_cycle();

    // Both strobes low together.
    addr     = 16'h8010;
    n_oe_mem = 1'b0;
    n_we_mem = 1'b0;
    for (int n = 0; n < 3; n++) idle_cycle();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("berr/set%0d", i), 16'(bus_err[i]), 16'd1);
      check_eq($sformatf("berr/rdy%0d", i), 16'(n_mem_rdy[i]), 16'd1);
    end
    n_oe_mem = 1'b1;
    n_we_mem = 1'b1;
    for (int n = 0; n < 3; n++) idle_cycle();
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("berr/sticky%0d", i), 16'(bus_err[i]), 16'd1);
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("berr/clear%0d", i), 16'(bus_err[i]), 16'd0);

    access(1'b0, 16'h8010, 8'h00, 1'b1, "rd8010_after_rst");
    check_eq("scoreboard/drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
